// File: rtl/mod_alu_pkg.sv
// Shared ALU definitions: sequential-multiplier FSM states and Booth step opcodes.
package mod_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } st_t;

    // Booth opcode is the bit pair {B[i], q-1}; 2'b11 is also a no-op
    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mod_multiplicador_seq_if.sv
// Handshake bus of the sequential multiplier: operand side (in_*) and result side (out_*).
interface mod_multiplicador_seq_if #(
    parameter int W     = 6,
    parameter int OUT_W = 2 * W
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic signed [W-1:0]     A;
    logic signed [W-1:0]     B;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] Y;
    logic                    ovf;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Y, ovf
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Y, ovf
    );

endinterface

// File: rtl/mod_booth_paso.sv
// Combinational radix-2 Booth step: acc +/- (A << i) selected by {B[i], q-1}.
module mod_booth_paso
    import mod_alu_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic signed [AW-1:0] acc,
    input  logic signed [AW-1:0] a_sh,
    input  logic        [1:0]    par,
    output logic signed [AW-1:0] acc_nxt
);

    always_comb begin
        acc_nxt = acc;
        case (par)
            BOOTH_ADD: acc_nxt = acc + a_sh;
            BOOTH_SUB: acc_nxt = acc - a_sh;
            default:   acc_nxt = acc;
        endcase
    end

endmodule

// File: rtl/mod_multiplicador_seq.sv
// Signed sequential radix-2 Booth multiplier, one recoded bit per clock, valid/ready on both sides.
// Optional macro MULT_SAT_EN: clamp Y to the OUT_W signed range and flag ovf; otherwise Y wraps, ovf=0.
module mod_multiplicador_seq
    import mod_alu_pkg::*;
#(
    parameter int W     = 6,
    parameter int OUT_W = 2 * W
) (
    input logic                   clk,
    input logic                   rst,
    mod_multiplicador_seq_if.slave bus
);

    localparam int AW = 2 * W;
    localparam int CW = $clog2(W);

    st_t                     state, state_nxt;
    logic signed [AW-1:0]    acc, acc_nxt, a_sh;
    logic        [W-1:0]     b_sh;
    logic                    q;
    logic        [CW-1:0]    cnt;
    logic                    last;
    logic signed [OUT_W-1:0] y_r, y_nxt;

    assign last = (cnt == CW'(W - 1));

    // A is kept pre-shifted and B shifted right, so the step always sees A<<i and {B[i],q-1}
    mod_booth_paso #(.AW(AW)) u_paso (
        .acc     (acc),
        .a_sh    (a_sh),
        .par     ({b_sh[0], q}),
        .acc_nxt (acc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid)  state_nxt = ST_BUSY;
            ST_BUSY: if (last)          state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            q    <= 1'b0;
            cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    acc  <= '0;
                    a_sh <= {{W{bus.A[W-1]}}, bus.A};
                    b_sh <= bus.B;
                    q    <= 1'b0;
                    cnt  <= '0;
                end
                ST_BUSY: begin
                    acc  <= acc_nxt;
                    a_sh <= a_sh <<< 1;
                    b_sh <= b_sh >> 1;
                    q    <= b_sh[0];
                    cnt  <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MULT_SAT_EN
    logic fits, ovf_nxt, ovf_r;

    // product fits when every bit above the OUT_W sign bit copies that sign bit
    always_comb begin
        fits    = (acc_nxt[AW-1:OUT_W-1] == {(AW-OUT_W+1){acc_nxt[OUT_W-1]}});
        y_nxt   = acc_nxt[OUT_W-1:0];
        ovf_nxt = 1'b0;
        if (!fits) begin
            ovf_nxt = 1'b1;
            y_nxt   = acc_nxt[AW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                          ovf_r <= 1'b0;
        else if (state == ST_BUSY && last) ovf_r <= ovf_nxt;
    end

    assign bus.ovf = ovf_r;
`else
    assign y_nxt   = OUT_W'(acc_nxt);
    assign bus.ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)                          y_r <= '0;
        else if (state == ST_BUSY && last) y_r <= y_nxt;
    end

    assign bus.Y = y_r;

endmodule
